// File: rtl/mem_access_unit.sv
// Data-memory access stage: word-wide synchronous RAM with one-cycle loads and word stores, and read-modify-write byte/half stores.
// Optional misalignment trap enabled by defining MAU_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Bytes,
  output logic        Busy,
  output logic        RdValid,
  output logic [31:0] MemData,
  output logic [1:0]  MemAdrLow,
  output logic [1:0]  Bytes2LoadOut,
  output logic        AlignErr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, RMW} state_t;

  state_t state_q, state_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] index;
  logic              is_byte, is_half, is_word;
  logic              accept, trap, go;
  logic              load_go, word_wr, part_wr;
  logic [1:0]        lane;

  logic [ADDR_W-1:0] rmw_idx;
  logic [31:0]       rmw_word;
  logic [15:0]       rmw_data;
  logic [1:0]        rmw_lane;
  logic              rmw_half;
  logic [31:0]       merged;

  // Address bits above the RAM depth are ignored so the index wraps.
  logic unused_addr;
  assign unused_addr = ^Addr[31:ADDR_W+2];

  assign index   = Addr[ADDR_W+1:2];
  assign is_byte = (Bytes == 2'd1);
  assign is_half = (Bytes == 2'd2);
  assign is_word = !is_byte && !is_half;
  assign Busy    = (state_q == RMW);
  assign accept  = ReqValid && !Busy;

`ifdef MAU_MISALIGN_TRAP_EN
  assign trap = (is_half && Addr[0]) || (is_word && (Addr[1:0] != 2'b00));
  assign lane = Addr[1:0];
`else
  // Misaligned halves and words are aligned down and treated as normal accesses.
  assign trap = 1'b0;
  assign lane = is_word ? 2'b00 : (is_half ? {Addr[1], 1'b0} : Addr[1:0]);
`endif

  assign go      = accept && !trap;
  assign load_go = go && !ReqWrite;
  assign word_wr = go && ReqWrite && is_word;
  assign part_wr = go && ReqWrite && !is_word;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable written in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (part_wr) state_d = RMW;
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    merged = rmw_word;
    if (rmw_half) merged[{rmw_lane[1], 4'b0000} +: 16] = rmw_data;
    else          merged[{rmw_lane, 3'b000} +: 8]     = rmw_data[7:0];
  end

  // NOTE: the RAM and its RMW capture registers have no reset; RAM contents must survive reset and the
  // capture registers are only consumed in RMW, which reset leaves.
  always_ff @(posedge Clk) begin
    if (word_wr) mem[index] <= WriteData;
    if (state_q == RMW) mem[rmw_idx] <= merged;
    if (part_wr) begin
      rmw_word <= mem[index];
      rmw_idx  <= index;
      rmw_lane <= lane;
      rmw_half <= is_half;
      rmw_data <= WriteData[15:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RdValid       <= 1'b0;
      MemData       <= '0;
      MemAdrLow     <= '0;
      Bytes2LoadOut <= '0;
    end else begin
      RdValid <= load_go;
      if (load_go) begin
        MemData       <= mem[index];
        MemAdrLow     <= lane;
        Bytes2LoadOut <= Bytes;
      end
    end
  end

`ifdef MAU_MISALIGN_TRAP_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) AlignErr <= 1'b0;
    else        AlignErr <= accept && trap;
  end
`else
  assign AlignErr = 1'b0;
`endif

endmodule
